// File: rtl/rsa_arbiter.sv
// Round-robin arbiter/sequencer sharing one RSA modexp core among NREQ requesters.
// Rejects modulus-0 requests without touching the core; a watchdog timeout latches a sticky fault.
module rsa_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] base_in,
    input  logic [NREQ*WIDTH-1:0] exp_in,
    input  logic [NREQ*WIDTH-1:0] mod_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  fault,
    output logic                  core_start,
    output logic [WIDTH-1:0]      core_base,
    output logic [WIDTH-1:0]      core_exp,
    output logic [WIDTH-1:0]      core_mod,
    input  logic                  core_end,
    input  logic [WIDTH-1:0]      core_out,
    output logic [2:0]            dbg_state_o
);

    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     gnt_q;
    logic [CW-1:0]     cnt_q;
    logic [NREQ-1:0]   ack_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic              fault_q;
    logic              core_start_q;
    logic [WIDTH-1:0]  core_base_q;
    logic [WIDTH-1:0]  core_exp_q;
    logic [WIDTH-1:0]  core_mod_q;

    logic              gnt_found_d;
    logic [IW-1:0]     gnt_idx_d;
    logic [NREQ-1:0]   gnt_oh_d;
    logic [NREQ-1:0]   gnt_q_oh;
    logic [IW1-1:0]    sum;
    logic [WIDTH-1:0]  sel_base;
    logic [WIDTH-1:0]  sel_exp;
    logic [WIDTH-1:0]  sel_mod;

    // Search from farthest to nearest after ptr, so the nearest pending requester wins.
    always_comb begin
        gnt_found_d = 1'b0;
        gnt_idx_d   = '0;
        sum         = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, ptr_q} + IW1'(k);
            if (sum >= IW1'(NREQ)) sum = sum - IW1'(NREQ);
            if (req[sum[IW-1:0]]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_base = '0;
        sel_exp  = '0;
        sel_mod  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_d == IW'(i)) begin
                sel_base = base_in[i*WIDTH +: WIDTH];
                sel_exp  = exp_in[i*WIDTH +: WIDTH];
                sel_mod  = mod_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt_oh_d = NREQ'(1) << gnt_idx_d;
    assign gnt_q_oh = NREQ'(1) << gnt_q;

    // Handshake: a requester holds req with stable operands until its one-cycle ack;
    // its result arrives later as a one-cycle rsp_valid bit, qualified by rsp_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            ptr_q        <= IW'(NREQ - 1);
            gnt_q        <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            core_start_q <= 1'b0;
            core_base_q  <= '0;
            core_exp_q   <= '0;
            core_mod_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found_d) begin
                        ack_q  <= gnt_oh_d;
                        gnt_q  <= gnt_idx_d;
                        busy_q <= 1'b1;
                        if (sel_mod != '0) begin
                            core_base_q  <= sel_base;
                            core_exp_q   <= sel_exp;
                            core_mod_q   <= sel_mod;
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_valid_q <= gnt_oh_d;
                            ptr_q       <= gnt_idx_d;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_START: begin
                    core_start_q <= 1'b0;
                    ack_q        <= '0;
                    cnt_q        <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A completion arriving on the last allowed cycle still counts as success.
                    if (core_end) begin
                        rsp_data_q  <= core_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q_oh;
                        ptr_q       <= gnt_q;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= gnt_q_oh;
                        fault_q     <= 1'b1;
                        state_q     <= S_FAULT;
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    ack_q       <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                S_FAULT: begin
                    rsp_valid_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign core_start  = core_start_q;
    assign core_base   = core_base_q;
    assign core_exp    = core_exp_q;
    assign core_mod    = core_mod_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rsa_arbiter.sv
// Self-checking bench for rsa_arbiter: behavioural modexp core, negedge monitor logs,
// round-robin order model and a result queue.
module tb_rsa_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] base_in = '0, exp_in = '0, mod_in = '0;
    logic [NREQ-1:0]       ack, rsp_valid;
    logic [WIDTH-1:0]      rsp_data, core_base, core_exp, core_mod;
    logic                  rsp_err, busy, fault, core_start;
    logic                  core_end = 1'b0;
    logic [WIDTH-1:0]      core_out = '0;
    logic [2:0]            dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    rsa_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .req(req),
        .base_in(base_in), .exp_in(exp_in), .mod_in(mod_in),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .fault(fault), .core_start(core_start),
        .core_base(core_base), .core_exp(core_exp), .core_mod(core_mod),
        .core_end(core_end), .core_out(core_out), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- reference functions ----------------
    function automatic logic [WIDTH-1:0] modexp(logic [WIDTH-1:0] b, logic [WIDTH-1:0] e,
                                                logic [WIDTH-1:0] m);
        logic [63:0] r, x;
        r = 64'(1) % 64'(m);
        x = 64'(b) % 64'(m);
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) r = (r * x) % 64'(m);
            x = (x * x) % 64'(m);
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic int rr_next(int last, logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int first_idx(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- behavioural core ----------------
    logic             core_en = 1'b1;
    int               core_lat = 0;
    int               cd = 0;
    logic [WIDTH-1:0] c_res = '0;
    int               end_cyc_q[$];

    always @(negedge clk) begin
        core_end = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_end = 1'b1;
                core_out = c_res;
                end_cyc_q.push_back(cyc);
            end
        end
        if (core_start && core_en) begin
            c_res = modexp(core_base, core_exp, core_mod);
            cd = (core_lat > 0) ? core_lat : int'($urandom_range(1, 6));
        end
    end

    // ---------------- monitor ----------------
    int               ack_idx_q[$], ack_cyc_q[$], start_cyc_q[$];
    int               rsp_idx_q[$], rsp_cyc_q[$], idle_cyc_q[$];
    logic [WIDTH-1:0] rsp_dat_q[$];
    logic             rsp_er_q[$];
    int               multi_hot = 0;

    always @(negedge clk) begin
        if ($countones(ack) > 1 || $countones(rsp_valid) > 1) multi_hot++;
        if (|ack) begin
            ack_idx_q.push_back(first_idx(ack));
            ack_cyc_q.push_back(cyc);
        end
        if (core_start) start_cyc_q.push_back(cyc);
        if (|rsp_valid) begin
            rsp_idx_q.push_back(first_idx(rsp_valid));
            rsp_dat_q.push_back(rsp_data);
            rsp_er_q.push_back(rsp_err);
            rsp_cyc_q.push_back(cyc);
        end
        if (!busy && rstn) idle_cyc_q.push_back(cyc);
    end

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    int               exp_idx_q[$];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_idx_q.delete(); ack_cyc_q.delete(); start_cyc_q.delete();
        rsp_idx_q.delete(); rsp_cyc_q.delete(); idle_cyc_q.delete();
        rsp_dat_q.delete(); rsp_er_q.delete(); end_cyc_q.delete();
        exp_q.delete(); exp_idx_q.delete();
    endtask

    task automatic drive_req(int i, logic [WIDTH-1:0] b, logic [WIDTH-1:0] e, logic [WIDTH-1:0] m);
        base_in[i*WIDTH +: WIDTH] = b;
        exp_in[i*WIDTH +: WIDTH]  = e;
        mod_in[i*WIDTH +: WIDTH]  = m;
        req[i] = 1'b1;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic wait_rsp(int n, int budget, bit hold);
        for (int t = 0; t < budget && rsp_idx_q.size() < n; t++) begin
            step();
            if (!hold) for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
        end
        if (rsp_idx_q.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_rsp: got %0d responses, required %0d", rsp_idx_q.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        n_cmp++;
        if ({ack, rsp_valid, rsp_err, busy, fault, core_start} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 0", {ack, rsp_valid, rsp_err, busy, fault, core_start});
        end
        n_cmp++;
        if ({rsp_data, core_base, core_exp, core_mod} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h, required 0", {rsp_data, core_base, core_exp, core_mod});
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single();
        int c;
        clear_logs();
        c = cyc;
        drive_req(1, 4, 13, 497);
        exp_q.push_back(32'd445);
        wait_rsp(1, 60, 0);
        n_cmp++;
        if (ack_idx_q.size() != 1 || ack_idx_q[0] != 1 || ack_cyc_q[0] != c + 1) begin
            n_err++;
            $display("FAIL single_ack: got %0d acks (first idx %0d), required one ack to 1 at cycle %0d",
                     ack_idx_q.size(), ack_idx_q.size() > 0 ? ack_idx_q[0] : -1, c + 1);
        end
        n_cmp++;
        if (start_cyc_q.size() != 1 || start_cyc_q[0] != c + 1) begin
            n_err++;
            $display("FAIL single_start: got %0d starts, required 1 at cycle %0d", start_cyc_q.size(), c + 1);
        end
        n_cmp++;
        if (rsp_idx_q.size() != 1 || rsp_idx_q[0] != 1 || rsp_er_q[0] !== 1'b0 || rsp_dat_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL single_rsp: got idx %0d data %0d, required idx 1 data %0d err 0",
                     rsp_idx_q.size() > 0 ? rsp_idx_q[0] : -1, rsp_dat_q.size() > 0 ? rsp_dat_q[0] : '0, exp_q[0]);
        end
        n_cmp++;
        if (end_cyc_q.size() != 1 || rsp_cyc_q.size() != 1 || rsp_cyc_q[0] != end_cyc_q[0] + 1) begin
            n_err++;
            $display("FAIL single_latency: rsp/end counts %0d/%0d, required rsp one cycle after core_end",
                     rsp_cyc_q.size(), end_cyc_q.size());
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || multi_hot != 0) begin
            n_err++;
            $display("FAIL single_idle: got busy %b multi_hot %0d, required 0 0", busy, multi_hot);
        end
    endtask

    task automatic test_two();
        pulse_reset();
        clear_logs();
        drive_req(0, 2, 10, 1000);
        drive_req(2, 3, 5, 7);
        exp_idx_q.push_back(0); exp_q.push_back(32'd24);
        exp_idx_q.push_back(2); exp_q.push_back(32'd5);
        wait_rsp(2, 100, 0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rsp_idx_q.size() <= k || rsp_idx_q[k] != exp_idx_q[k] || rsp_dat_q[k] !== exp_q[k] || rsp_er_q[k] !== 1'b0) begin
                n_err++;
                $display("FAIL two_rsp%0d: got idx %0d data %0d, required idx %0d data %0d", k,
                         rsp_idx_q.size() > k ? rsp_idx_q[k] : -1, rsp_dat_q.size() > k ? rsp_dat_q[k] : '0,
                         exp_idx_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (start_cyc_q.size() != 2) begin
            n_err++;
            $display("FAIL two_starts: got %0d, required 2", start_cyc_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] b[NREQ], e[NREQ], m[NREQ];
        int last, g, idle_n;
        pulse_reset();
        clear_logs();
        last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            b[i] = $urandom;
            e[i] = $urandom;
            m[i] = $urandom | 32'd1;
        end
        for (int k = 0; k < 8; k++) begin
            g = rr_next(last, '1);
            exp_idx_q.push_back(g);
            exp_q.push_back(modexp(b[g], e[g], m[g]));
            last = g;
        end
        for (int i = 0; i < NREQ; i++) drive_req(i, b[i], e[i], m[i]);
        wait_rsp(8, 300, 1);
        req = '0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (rsp_idx_q.size() <= k || rsp_idx_q[k] != exp_idx_q[k] || rsp_dat_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL rr_rsp%0d: got idx %0d data %h, required idx %0d data %h", k,
                         rsp_idx_q.size() > k ? rsp_idx_q[k] : -1, rsp_dat_q.size() > k ? rsp_dat_q[k] : '0,
                         exp_idx_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (start_cyc_q.size() != 8 || ack_idx_q.size() != 8) begin
            n_err++;
            $display("FAIL rr_counts: got %0d starts %0d acks, required 8 8", start_cyc_q.size(), ack_idx_q.size());
        end
        idle_n = 0;
        if (ack_cyc_q.size() > 0 && rsp_cyc_q.size() >= 8)
            foreach (idle_cyc_q[k]) if (idle_cyc_q[k] > ack_cyc_q[0] && idle_cyc_q[k] < rsp_cyc_q[7]) idle_n++;
        n_cmp++;
        if (idle_n != 7) begin
            n_err++;
            $display("FAIL rr_busy_gaps: got %0d idle cycles, required 7", idle_n);
        end
        step();
        step();
    endtask

    task automatic test_reject();
        int c;
        clear_logs();
        c = cyc;
        drive_req(3, $urandom, $urandom, 0);
        wait_rsp(1, 20, 0);
        n_cmp++;
        if (ack_idx_q.size() != 1 || ack_idx_q[0] != 3 || ack_cyc_q[0] != c + 1 ||
            rsp_cyc_q.size() != 1 || rsp_cyc_q[0] != c + 1 || rsp_idx_q[0] != 3) begin
            n_err++;
            $display("FAIL reject_timing: got %0d acks %0d rsps, required ack and rsp to 3 at cycle %0d",
                     ack_idx_q.size(), rsp_cyc_q.size(), c + 1);
        end
        n_cmp++;
        if (rsp_er_q.size() != 1 || rsp_er_q[0] !== 1'b1 || rsp_dat_q[0] !== '0 || start_cyc_q.size() != 0) begin
            n_err++;
            $display("FAIL reject_rsp: got err %b data %0d starts %0d, required 1 0 0",
                     rsp_er_q.size() > 0 ? rsp_er_q[0] : 1'bx, rsp_dat_q.size() > 0 ? rsp_dat_q[0] : '0,
                     start_cyc_q.size());
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reject_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_tie();
        logic [WIDTH-1:0] b, e, m;
        clear_logs();
        core_lat = TIMEOUT;
        b = $urandom; e = $urandom; m = $urandom | 32'h1000_0001;
        exp_q.push_back(modexp(b, e, m));
        drive_req(2, b, e, m);
        wait_rsp(1, 80, 0);
        core_lat = 0;
        n_cmp++;
        if (rsp_idx_q.size() != 1 || rsp_er_q[0] !== 1'b0 || rsp_dat_q[0] !== exp_q[0] || fault !== 1'b0) begin
            n_err++;
            $display("FAIL tie_rsp: got err %b data %h fault %b, required 0 %h 0",
                     rsp_er_q.size() > 0 ? rsp_er_q[0] : 1'bx, rsp_dat_q.size() > 0 ? rsp_dat_q[0] : '0,
                     fault, exp_q[0]);
        end
        n_cmp++;
        if (start_cyc_q.size() != 1 || rsp_cyc_q.size() != 1 || rsp_cyc_q[0] - start_cyc_q[0] != TIMEOUT + 1) begin
            n_err++;
            $display("FAIL tie_latency: got %0d cycles, required %0d",
                     (rsp_cyc_q.size() > 0 && start_cyc_q.size() > 0) ? rsp_cyc_q[0] - start_cyc_q[0] : -1, TIMEOUT + 1);
        end
        step();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        core_lat = 10;
        drive_req(0, $urandom, $urandom, $urandom | 32'd1);
        for (int t = 0; t < 20 && start_cyc_q.size() == 0; t++) begin
            step();
            if (ack[0]) req[0] = 1'b0;
        end
        req[0] = 1'b0;
        step(); step(); step();
        rstn = 1'b0;
        step();
        n_cmp++;
        if ({ack, rsp_valid, rsp_err, busy, fault, core_start} !== '0 || {core_base, core_exp, core_mod} !== '0) begin
            n_err++;
            $display("FAIL midreset_values: got ctrl %b, required 0", {ack, rsp_valid, rsp_err, busy, fault, core_start});
        end
        rstn = 1'b1;
        for (int t = 0; t < 12; t++) step();
        core_lat = 0;
        n_cmp++;
        if (rsp_idx_q.size() != 0 || end_cyc_q.size() != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_late_end: got %0d rsps %0d core_ends busy %b, required 0 1 0",
                     rsp_idx_q.size(), end_cyc_q.size(), busy);
        end
        clear_logs();
        drive_req(0, 5, 3, 13);
        exp_q.push_back(32'd8);
        wait_rsp(1, 60, 0);
        n_cmp++;
        if (rsp_idx_q.size() != 1 || rsp_idx_q[0] != 0 || rsp_dat_q[0] !== exp_q[0] || rsp_er_q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_fresh: got idx %0d data %0d, required idx 0 data 8",
                     rsp_idx_q.size() > 0 ? rsp_idx_q[0] : -1, rsp_dat_q.size() > 0 ? rsp_dat_q[0] : '0);
        end
        step();
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] b, e, m;
        clear_logs();
        core_en = 1'b0;
        drive_req(2, $urandom, $urandom, $urandom | 32'd1);
        wait_rsp(1, 60, 0);
        n_cmp++;
        if (rsp_idx_q.size() != 1 || rsp_idx_q[0] != 2 || rsp_er_q[0] !== 1'b1 || rsp_dat_q[0] !== '0) begin
            n_err++;
            $display("FAIL timeout_rsp: got idx %0d err %b, required idx 2 err 1 data 0",
                     rsp_idx_q.size() > 0 ? rsp_idx_q[0] : -1, rsp_er_q.size() > 0 ? rsp_er_q[0] : 1'bx);
        end
        n_cmp++;
        if (start_cyc_q.size() != 1 || rsp_cyc_q.size() != 1 || rsp_cyc_q[0] - start_cyc_q[0] != TIMEOUT + 1) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d",
                     (rsp_cyc_q.size() > 0 && start_cyc_q.size() > 0) ? rsp_cyc_q[0] - start_cyc_q[0] : -1, TIMEOUT + 1);
        end
        b = $urandom; e = $urandom; m = $urandom | 32'd1;
        drive_req(1, b, e, m);
        for (int t = 0; t < 40; t++) step();
        n_cmp++;
        if (ack_idx_q.size() != 1 || start_cyc_q.size() != 1 || fault !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: got %0d acks %0d starts fault %b busy %b, required 1 1 1 1",
                     ack_idx_q.size(), start_cyc_q.size(), fault, busy);
        end
        core_en = 1'b1;
        rstn = 1'b0;
        step();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: got fault %b, required 0", fault);
        end
        rstn = 1'b1;
        clear_logs();
        exp_q.push_back(modexp(b, e, m));
        wait_rsp(1, 60, 0);
        n_cmp++;
        if (rsp_idx_q.size() != 1 || rsp_idx_q[0] != 1 || rsp_dat_q[0] !== exp_q[0] || rsp_er_q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_recover: got idx %0d data %h, required idx 1 data %h",
                     rsp_idx_q.size() > 0 ? rsp_idx_q[0] : -1, rsp_dat_q.size() > 0 ? rsp_dat_q[0] : '0, exp_q[0]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_two();
        test_round_robin();
        test_reject();
        test_tie();
        test_reset_mid();
        test_timeout();
        n_cmp++;
        if (multi_hot != 0) begin
            n_err++;
            $display("FAIL onehot: got %0d multi-hot cycles, required 0", multi_hot);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rsa_arbiter.md
# rsa_arbiter

Round-robin arbiter and sequencer that shares one RSA modular-exponentiation core (start/end handshake, 32-bit base/exponent/modulus) between NREQ independent requesters. It sits between the requester-side interfaces and the core. It latches the winning requester's operands, pulses the core start, waits for core completion under a watchdog, and returns the result only to the granted requester. It also rejects malformed requests (modulus 0) without occupying the core.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 32: operand/result width
- TIMEOUT, 4096: max cycles in WAIT before fault; must exceed worst-case core latency
- clk  in  1  clock
- rstn  in  1  reset rstn, asynchronous, active-low; clock clk
- req  in  NREQ  request per requester; held high with stable operands until ack
- base_in  in  NREQ*WIDTH  operand base, requester i at [i*WIDTH +: WIDTH]
- exp_in  in  NREQ*WIDTH  exponent, same packing
- mod_in  in  NREQ*WIDTH  modulus, same packing
- ack  out  NREQ  one-hot, one-cycle pulse: operands captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_data/rsp_err valid for that requester
- rsp_data  out  WIDTH  result; holds last value until next response
- rsp_err  out  1  qualifies rsp_valid: 1 = rejected or timed out, rsp_data = 0
- busy  out  1  high in any state except IDLE
- fault  out  1  sticky watchdog fault, cleared only by reset
- core_start  out  1  one-cycle start pulse to core
- core_base, core_exp, core_mod  out  WIDTH each  registered operands, stable from core_start until next grant
- core_end  in  1  core completion strobe
- core_out  in  WIDTH  core result, valid with core_end

## Operation
- States: IDLE, START, WAIT, RESP, FAULT.
- Arbitration pointer ptr = last served index; search order ptr+1, ptr+2, … wrapping mod NREQ. After reset ptr = NREQ-1, so requester 0 has top priority.
- IDLE, any req high: winner g chosen. ack[g]<=1, g registered, busy<=1.
  - mod_in[g] != 0: core_* <= operands of g, core_start<=1, go START.
  - mod_in[g] == 0: rsp_err<=1, rsp_data<=0, rsp_valid[g]<=1, ptr<=g, go RESP. Core untouched.
- START: core_start<=0, ack<=0, WAIT counter cleared, go WAIT.
- WAIT: counter increments each cycle.
  - core_end high: rsp_data<=core_out, rsp_err<=0, rsp_valid[g]<=1, ptr<=g, go RESP.
  - Else if counter == TIMEOUT-1: rsp_err<=1, rsp_data<=0, rsp_valid[g]<=1, fault<=1, go FAULT.
  - core_end and timeout in the same cycle: core_end wins.
- RESP: rsp_valid<=0, ack<=0, busy<=0, go IDLE.
- FAULT: rsp_valid<=0. No further acks or core_start until reset. busy=1, fault=1.
- core_end outside WAIT is ignored.
- A req still high in the IDLE cycle after RESP is a new request. Requesters drop req after ack.
- Requests arriving while busy wait, are not acked, and are never lost.

## Timing
- Reset values: ack=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, fault=0, core_start=0, core_base/exp/mod=0, state IDLE, ptr=NREQ-1.
- Reset asserted mid-operation aborts immediately to reset values. In-flight request gets no response. A late core_end after reset is ignored (state IDLE).
- Request sampled at edge n. ack[g] and core_start are high in cycle n+1 only.
- core_end sampled at edge m. rsp_valid[g] is high in cycle m+1. IDLE is re-entered at m+2, so the next grant is sampled no earlier than edge m+2.
- Modulus-0 reject: ack and rsp_valid both high in cycle n+1, IDLE at n+2.
- Core latency (core_start to core_end) must be ≥ 1 cycle. The arbiter adds 3 cycles of overhead per operation.

## Test plan
- Single request, req[1] with base=4, exp=13, mod=497, behavioural core: ack[1] one cycle, one core_start, rsp_valid[1] with rsp_data=445, rsp_err=0, no other rsp_valid bit.
- After reset, req[0] and req[2] asserted together: requester 0 is served first, then 2. Each gets only its own result (2^10 mod 1000=24; 3^5 mod 7=5).
- All four req held continuously for 8 grants: grant order 0,1,2,3,0,1,2,3. Exactly one core_start per grant. busy low exactly one cycle between operations.
- req[3] with mod=0: ack[3] and rsp_valid[3] in the same cycle, rsp_err=1, rsp_data=0, core_start never asserted.
- Core stub never asserts core_end, TIMEOUT=16: rsp_valid[g] with rsp_err=1 exactly 16 cycles into WAIT, fault stays 1, later requests never acked until rstn pulse.
- rstn pulsed low during WAIT, then core_end arrives: all outputs return to reset values, no rsp_valid is produced, and a fresh req[0] completes normally.
